// File: rtl/sdram_arb.sv
// Two-port arbiter in front of a single-operation SDRAM controller.
// One operation is in flight at a time: grant, raise a strobe, wait for the
// controller's ready to fall and rise again, ack the client, then leave one
// low-strobe cycle so the controller sees a fresh rising edge next time.
module sdram_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [26:0] p0_addr,
  input  logic [15:0] p0_din,
  input  logic [1:0]  p0_wtbt,
  output logic [15:0] p0_dout,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [26:0] p1_addr,
  input  logic [15:0] p1_din,
  input  logic [1:0]  p1_wtbt,
  output logic [15:0] p1_dout,
  output logic        p1_ack,
  output logic [26:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, GAP} state_t;

  state_t state;
  logic   grant;       // port that owns the operation in flight
  logic   last_grant;  // port granted most recently, for round-robin ties
  logic   gnt_we;      // latched direction of the operation in flight
  logic   any_req;
  logic   pick;        // port that would be granted this cycle

  // Arbitration choice: on a tie either port 0 (fixed) or the port not served last
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      pick = ~p0_req;
    end
  end

  // Operation sequencer with registered strobes, acks and read data
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      gnt_we     <= 1'b0;
      last_grant <= 1'b1;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wtbt   <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_dout    <= '0;
      p1_dout    <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          // ready low means the controller is still starting up
          if (mem_ready && any_req) begin
            grant      <= pick;
            last_grant <= pick;
            gnt_we     <= pick ? p1_we   : p0_we;
            mem_addr   <= pick ? p1_addr : p0_addr;
            mem_din    <= pick ? p1_din  : p0_din;
            mem_wtbt   <= pick ? p1_wtbt : p0_wtbt;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we <= gnt_we;
          mem_rd <= ~gnt_we;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          // ready still high here is left over from the previous operation
          if (!mem_ready) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            if (grant) begin
              p1_ack <= 1'b1;
              if (!gnt_we) p1_dout <= mem_dout;
            end else begin
              p0_ack <= 1'b1;
              if (!gnt_we) p0_dout <= mem_dout;
            end
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: randomized clients and a controller model with random
// ready timing, checked every cycle against a transaction-level reference.
module tb_sdram_arb;
  localparam bit FIXED_PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [26:0] p0_addr = '0;
  logic [15:0] p0_din = '0;
  logic [1:0]  p0_wtbt = '0;
  logic [15:0] p0_dout;
  logic        p0_ack;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [26:0] p1_addr = '0;
  logic [15:0] p1_din = '0;
  logic [1:0]  p1_wtbt = '0;
  logic [15:0] p1_dout;
  logic        p1_ack;
  logic [26:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wtbt;
  logic        mem_we, mem_rd;
  logic [15:0] mem_dout = '0;
  logic        mem_ready = 1'b0;

  sdram_arb #(.FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .init_n(init_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_wtbt(p0_wtbt), .p0_dout(p0_dout), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_wtbt(p1_wtbt), .p1_dout(p1_dout), .p1_ack(p1_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (transaction level, edge counted) ----
  bit          m_busy, m_seen_low, m_strobe, m_ack0, m_ack1, m_we, m_port;
  bit          m_last = 1'b1;
  int          m_age, m_cool;
  logic [26:0] m_addr;
  logic [15:0] m_din, m_dout0, m_dout1;
  logic [1:0]  m_wtbt;

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      m_busy = 0; m_seen_low = 0; m_strobe = 0; m_ack0 = 0; m_ack1 = 0;
      m_last = 1; m_age = 0; m_cool = 0; m_dout0 = '0; m_dout1 = '0;
    end else begin
      m_ack0 = 0; m_ack1 = 0;
      if (m_busy) begin
        m_age++;
        if (m_age == 1) m_strobe = 1;                 // strobe one cycle after grant
        else if (m_seen_low && mem_ready) begin       // first ready after a low = done
          m_busy = 0; m_strobe = 0; m_cool = 1;
          if (m_port) m_ack1 = 1; else m_ack0 = 1;
          if (!m_we) begin
            if (m_port) m_dout1 = mem_dout; else m_dout0 = mem_dout;
          end
        end else if (!mem_ready) m_seen_low = 1;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (mem_ready && (p0_req || p1_req)) begin
        if (p0_req && p1_req) m_port = FIXED_PRIO ? 1'b0 : !m_last;
        else m_port = p1_req;
        m_last = m_port;
        m_we   = m_port ? p1_we   : p0_we;
        m_addr = m_port ? p1_addr : p0_addr;
        m_din  = m_port ? p1_din  : p0_din;
        m_wtbt = m_port ? p1_wtbt : p0_wtbt;
        m_busy = 1; m_age = 0; m_seen_low = 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("strobe_excl", {31'b0, mem_we & mem_rd}, 32'd0);
      chk("mem_we", {31'b0, mem_we}, {31'b0, m_strobe & m_we});
      chk("mem_rd", {31'b0, mem_rd}, {31'b0, m_strobe & ~m_we});
      chk("p0_ack", {31'b0, p0_ack}, {31'b0, m_ack0});
      chk("p1_ack", {31'b0, p1_ack}, {31'b0, m_ack1});
      chk("p0_dout", {16'b0, p0_dout}, {16'b0, m_dout0});
      chk("p1_dout", {16'b0, p1_dout}, {16'b0, m_dout1});
      if (m_busy) begin
        chk("mem_addr", {5'b0, mem_addr}, {5'b0, m_addr});
        chk("mem_din", {16'b0, mem_din}, {16'b0, m_din});
        chk("mem_wtbt", {30'b0, mem_wtbt}, {30'b0, m_wtbt});
      end
    end
  end

  // ---------------- monitor: strobe rises and ack counts ----------------
  int          strobe_rises = 0, ack0_cnt = 0, ack1_cnt = 0;
  bit          s_prev = 0, rise_we;
  logic [15:0] rise_din;
  logic [1:0]  rise_wtbt;
  always @(negedge clk) begin
    if ((mem_we | mem_rd) && !s_prev) begin
      strobe_rises++; rise_din = mem_din; rise_wtbt = mem_wtbt; rise_we = mem_we;
    end
    s_prev = mem_we | mem_rd;
    if (p0_ack) ack0_cnt++;
    if (p1_ack) ack1_cnt++;
  end

  // ---------------- controller model ----------------
  bit ctl_hold_low = 1'b1, ctl_fix_beef = 1'b0;
  int ctl_force_d1 = -1, ctl_force_len = -1, ready_rise_cyc = 0;
  initial begin : ctl
    int phase, dly, len;
    bit prev, rise;
    phase = 0; dly = 0; len = 0; prev = 0;
    forever begin
      @(negedge clk);
      mem_dout = ctl_fix_beef ? 16'hBEEF : 16'($urandom);
      if (!init_n || ctl_hold_low) begin
        phase = 0; prev = 0; mem_ready = !ctl_hold_low;
      end else begin
        rise = (mem_we | mem_rd) && !prev;
        prev = mem_we | mem_rd;
        if (phase == 0) begin
          mem_ready = 1'b1;
          if (rise) begin
            dly = (ctl_force_d1 >= 0) ? ctl_force_d1 : int'($urandom_range(0, 2));
            len = (ctl_force_len > 0) ? ctl_force_len : int'($urandom_range(1, 3));
            phase = 1;
          end
        end
        if (phase == 1) begin
          if (dly == 0) begin mem_ready = 1'b0; phase = 2; end
          else dly--;
        end else if (phase == 2) begin
          len--;
          if (len == 0) begin mem_ready = 1'b1; phase = 0; ready_rise_cyc = cyc; end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int port, input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin got = 1; break; end
    end
  endtask

  task automatic new_req(input int port);
    if (port == 0) begin
      p0_req = 1; p0_we = 1'($urandom); p0_addr = 27'($urandom);
      p0_din = 16'($urandom); p0_wtbt = 2'($urandom);
    end else begin
      p1_req = 1; p1_we = 1'($urandom); p1_addr = 27'($urandom);
      p1_din = 16'($urandom); p1_wtbt = 2'($urandom);
    end
  endtask

  // ---------------- directed sequence, then random traffic ----------------
  initial begin : main
    bit got;
    int cnt, a0, nacks, guard, r0, a_tot, exp_p, got_p;
    int order[$];

    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {5'b0, mem_addr}, 32'd0);
    chk("rst_mem_din_wtbt", {14'b0, mem_din, mem_wtbt}, 32'd0);
    chk("rst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
    chk("rst_douts", {p0_dout, p1_dout}, 32'd0);
    @(negedge clk); #2 init_n = 1;

    // controller held in startup: no strobe until ready, then one write
    p1_req = 1; p1_we = 1; p1_addr = 27'h1234567; p1_din = 16'hA5C3; p1_wtbt = 2'b10;
    repeat (100) @(negedge clk);
    chk("startup_no_strobe", strobe_rises, 32'd0);
    ctl_hold_low = 0;
    wait_ack(1, 50, got);
    chk("startup_ack", {31'b0, got}, 32'd1);
    p1_req = 0;
    chk("startup_ops", strobe_rises, 32'd1);
    chk("startup_we", {31'b0, rise_we}, 32'd1);
    chk("startup_din", {16'b0, rise_din}, 32'hA5C3);
    chk("startup_wtbt", {30'b0, rise_wtbt}, 32'd2);
    chk("write_keeps_dout", {16'b0, p1_dout}, 32'd0);

    // single read returning 0xBEEF
    repeat (3) @(negedge clk);
    a0 = ack0_cnt; ctl_fix_beef = 1;
    p0_req = 1; p0_we = 0; p0_addr = 27'h0000100; p0_din = 16'h1111; p0_wtbt = 2'b11;
    wait_ack(0, 50, got);
    chk("read_ack", {31'b0, got}, 32'd1);
    p0_req = 0;
    chk("read_dout", {16'b0, p0_dout}, 32'hBEEF);
    @(negedge clk);
    chk("read_strobe_drops", {31'b0, mem_rd}, 32'd0);
    ctl_fix_beef = 0;
    repeat (5) @(negedge clk);
    chk("read_one_ack", ack0_cnt - a0, 32'd1);

    // ready low for a single cycle: ack exactly one cycle after it returns
    ctl_force_d1 = 0; ctl_force_len = 1;
    p1_req = 1; p1_we = 0; p1_addr = 27'h0002000; p1_din = 16'h2222; p1_wtbt = 2'b01;
    wait_ack(1, 50, got);
    chk("fast_ack", {31'b0, got}, 32'd1);
    p1_req = 0;
    chk("fast_latency", cyc - ready_rise_cyc, 32'd1);
    ctl_force_d1 = -1; ctl_force_len = -1;

    // contention: both ports request together and keep requesting
    repeat (3) @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 27'h0000010; p0_din = 16'h0A0A; p0_wtbt = 2'b11;
    p1_req = 1; p1_we = 0; p1_addr = 27'h0000020; p1_din = 16'h0B0B; p1_wtbt = 2'b11;
    nacks = 0; guard = 0;
    while (nacks < 4 && guard < 200) begin
      @(negedge clk); guard++;
      if (p0_ack) begin order.push_back(0); nacks++; end
      if (p1_ack) begin order.push_back(1); nacks++; end
    end
    p0_req = 0; p1_req = 0;
    chk("contention_acks", nacks, 32'd4);
    for (int k = 0; k < 4; k++) begin
      exp_p = FIXED_PRIO ? 0 : (k % 2);
      got_p = (k < order.size()) ? order[k] : -1;
      chk("contention_order", got_p, exp_p);
    end

    // reset while waiting for ready to return
    repeat (3) @(negedge clk);
    ctl_force_d1 = 0; ctl_force_len = 10;
    p0_req = 1; p0_we = 1; p0_addr = 27'h3ABCDEF; p0_din = 16'h5A5A; p0_wtbt = 2'b01;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (mem_we && !mem_ready) cnt++;
    end
    chk("rst_reached_wait", cnt, 32'd3);
    a0 = ack0_cnt;
    #2 init_n = 0;
    #1;
    chk("rst_strobe_low", {30'b0, mem_we, mem_rd}, 32'd0);
    chk("rst_ack_low", {31'b0, p0_ack}, 32'd0);
    p0_req = 0; ctl_force_d1 = -1; ctl_force_len = -1;
    repeat (2) @(negedge clk);
    #2 init_n = 1;
    repeat (12) @(negedge clk);
    chk("rst_no_ack", ack0_cnt - a0, 32'd0);
    p1_req = 1; p1_we = 0; p1_addr = 27'h0004444; p1_din = 16'h3333; p1_wtbt = 2'b00;
    wait_ack(1, 50, got);
    chk("post_rst_ack", {31'b0, got}, 32'd1);
    p1_req = 0;

    // random traffic with occasional withdrawal after grant
    repeat (3) @(negedge clk);
    r0 = strobe_rises; a_tot = ack0_cnt + ack1_cnt;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (p0_req && p0_ack) begin
        if ($urandom % 2) new_req(0); else p0_req = 0;
      end else if (p0_req && (mem_we | mem_rd) && mem_addr == p0_addr && ($urandom % 8 == 0)) begin
        p0_req = 0;
      end else if (!p0_req && ($urandom % 3 == 0)) new_req(0);
      if (p1_req && p1_ack) begin
        if ($urandom % 2) new_req(1); else p1_req = 0;
      end else if (p1_req && (mem_we | mem_rd) && mem_addr == p1_addr && ($urandom % 8 == 0)) begin
        p1_req = 0;
      end else if (!p1_req && ($urandom % 3 == 0)) new_req(1);
    end
    p0_req = 0; p1_req = 0;
    repeat (30) @(negedge clk);
    chk("grant_ack_balance", ack0_cnt + ack1_cnt - a_tot, strobe_rises - r0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
